// File: rtl/move_controller.sv
// Turns debounced player buttons into cursor moves and one-cycle move requests
// for GameState, then waits for and reacts to the resulting GameStatus.
module move_controller #(
   parameter int RESP_WAIT    = 2,
   parameter bit START_PLAYER = 1'b1,
   parameter int CURSOR_INIT  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_sel,
   input  logic [8:0] X_state,
   input  logic [8:0] O_state,
   input  logic [2:0] GameStatus,
   output logic       move,
   output logic       player,
   output logic [3:0] nextMove,
   output logic       busy,
   output logic       invalid,
   output logic       game_over
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t     state, state_d;
   logic [4:0] btn_now, btn_prev, press;
   logic [3:0] cnt, cnt_d;
   logic [3:0] cursor, cursor_d;
   logic       player_q, player_d;
   logic       invalid_q, invalid_d;
   logic [8:0] occ;

   // Bit order {sel, up, down, left, right} also encodes press priority.
   assign btn_now = {btn_sel, btn_up, btn_down, btn_left, btn_right};
   assign press   = btn_now & ~btn_prev;
   assign occ     = X_state | O_state;

   function automatic logic [1:0] col_of(input logic [3:0] c);
      case (c)
         4'd0, 4'd3, 4'd6: col_of = 2'd0;
         4'd1, 4'd4, 4'd7: col_of = 2'd1;
         default:          col_of = 2'd2;
      endcase
   endfunction

   function automatic logic [3:0] step_up(input logic [3:0] c);
      step_up = (c >= 4'd3) ? c - 4'd3 : c + 4'd6;
   endfunction

   function automatic logic [3:0] step_down(input logic [3:0] c);
      step_down = (c < 4'd6) ? c + 4'd3 : c - 4'd6;
   endfunction

   function automatic logic [3:0] step_left(input logic [3:0] c);
      step_left = (col_of(c) == 2'd0) ? c + 4'd2 : c - 4'd1;
   endfunction

   function automatic logic [3:0] step_right(input logic [3:0] c);
      step_right = (col_of(c) == 2'd2) ? c - 4'd2 : c + 4'd1;
   endfunction

   // State register; button history keeps updating in every state so
   // presses made while busy are never replayed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         btn_prev  <= 5'd0;
         cnt       <= 4'd0;
         cursor    <= 4'(CURSOR_INIT);
         player_q  <= START_PLAYER;
         invalid_q <= 1'b0;
      end else begin
         state     <= state_d;
         btn_prev  <= btn_now;
         cnt       <= cnt_d;
         cursor    <= cursor_d;
         player_q  <= player_d;
         invalid_q <= invalid_d;
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      cursor_d  = cursor;
      player_d  = player_q;
      invalid_d = invalid_q;
      case (state)
         IDLE: begin
            if (press[4]) begin
               if (occ[cursor]) begin
                  invalid_d = 1'b1;
               end else begin
                  invalid_d = 1'b0;
                  state_d   = ISSUE;
               end
            end else if (press[3]) begin
               cursor_d  = step_up(cursor);
               invalid_d = 1'b0;
            end else if (press[2]) begin
               cursor_d  = step_down(cursor);
               invalid_d = 1'b0;
            end else if (press[1]) begin
               cursor_d  = step_left(cursor);
               invalid_d = 1'b0;
            end else if (press[0]) begin
               cursor_d  = step_right(cursor);
               invalid_d = 1'b0;
            end
         end
         ISSUE: begin
            cnt_d   = 4'(RESP_WAIT);
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt - 4'd1;
            if (cnt <= 4'd1) state_d = CHECK;
         end
         CHECK: begin
            case (GameStatus)
               3'd0: begin
                  player_d = ~player_q;
                  state_d  = IDLE;
               end
               3'd1, 3'd2, 3'd3: state_d = DONE;
               default: begin
                  invalid_d = 1'b1;
                  state_d   = IDLE;
               end
            endcase
         end
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs.
   always_comb begin
      move      = (state == ISSUE);
      busy      = (state == ISSUE) || (state == WAIT) || (state == CHECK);
      game_over = (state == DONE);
      player    = player_q;
      nextMove  = cursor;
      invalid   = invalid_q;
   end

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: cursor wrap, move handshake timing,
// rejection paths, game end and reset during a move request.
module tb_move_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_up, btn_down, btn_left, btn_right, btn_sel;
   logic [8:0] X_state, O_state;
   logic [2:0] GameStatus;
   logic       move, player, busy, invalid, game_over;
   logic [3:0] nextMove;

   int passed = 0;
   int total  = 0;
   int pulses;

   move_controller #(.RESP_WAIT(2), .START_PLAYER(1'b1), .CURSOR_INIT(4)) dut (
      .clk(clk), .rst(rst),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .btn_sel(btn_sel),
      .X_state(X_state), .O_state(O_state), .GameStatus(GameStatus),
      .move(move), .player(player), .nextMove(nextMove), .busy(busy),
      .invalid(invalid), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Pulse one direction button for a single sampling edge.
   task automatic press_dir(input int which);
      case (which)
         0: btn_up = 1'b1;
         1: btn_down = 1'b1;
         2: btn_left = 1'b1;
         default: btn_right = 1'b1;
      endcase
      cyc(1);
      {btn_up, btn_down, btn_left, btn_right} = 4'b0;
      cyc(1);
   endtask

   // Press sel for one sampling edge and count move pulses over the full
   // ISSUE/WAIT/CHECK window that follows.
   task automatic do_sel(output int n);
      n = 0;
      btn_sel = 1'b1;
      cyc(1);
      btn_sel = 1'b0;
      if (move) n++;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         if (move) n++;
      end
   endtask

   initial begin
      rst = 1'b1;
      {btn_up, btn_down, btn_left, btn_right, btn_sel} = 5'b0;
      X_state = 9'd0; O_state = 9'd0; GameStatus = 3'd0;
      cyc(2);
      rst = 1'b0;
      cyc(5);
      chk("rst_nextMove", nextMove, 4);
      chk("rst_player", player, 1);
      chk("rst_move", move, 0);
      chk("rst_invalid", invalid, 0);
      chk("rst_game_over", game_over, 0);
      chk("rst_busy", busy, 0);

      press_dir(0); chk("up_4_to_1", nextMove, 1);
      press_dir(2); chk("left_1_to_0", nextMove, 0);
      press_dir(2); chk("left_wrap_0_to_2", nextMove, 2);
      press_dir(1); chk("down_2_to_5", nextMove, 5);
      press_dir(3); chk("right_wrap_5_to_3", nextMove, 3);
      press_dir(0); chk("up_wrap_3_to_0", nextMove, 0);
      press_dir(1); press_dir(1); press_dir(1);
      chk("down_wrap_back_0", nextMove, 0);

      btn_right = 1'b1;
      cyc(10);
      btn_right = 1'b0;
      cyc(1);
      chk("held_right_one_step", nextMove, 1);
      press_dir(1);
      chk("down_1_to_4", nextMove, 4);

      // Move with GameStatus running: timing checked edge by edge.
      btn_sel = 1'b1;
      cyc(1);
      btn_sel = 1'b0;
      chk("sel_move_pulse", move, 1);
      chk("sel_busy_issue", busy, 1);
      cyc(1);
      chk("wait1_move_low", move, 0);
      chk("wait1_busy", busy, 1);
      cyc(1);
      chk("wait2_busy", busy, 1);
      chk("wait2_player", player, 1);
      cyc(1);
      chk("check_busy", busy, 1);
      chk("check_player", player, 1);
      chk("check_nextMove_stable", nextMove, 4);
      cyc(1);
      chk("toggle_player", player, 0);
      chk("back_idle_busy", busy, 0);

      // Occupied cell is rejected locally.
      X_state = 9'b0_0001_0000;
      do_sel(pulses);
      chk("occupied_no_pulse", pulses, 0);
      chk("occupied_invalid", invalid, 1);
      chk("occupied_player", player, 0);
      press_dir(2);
      chk("left_clears_invalid", invalid, 0);
      chk("left_4_to_3", nextMove, 3);
      X_state = 9'd0;

      // GameStatus invalid (and an out-of-range code) from GameState.
      GameStatus = 3'd4;
      do_sel(pulses);
      chk("status4_pulse", pulses, 1);
      chk("status4_invalid", invalid, 1);
      chk("status4_player", player, 0);
      GameStatus = 3'd6;
      do_sel(pulses);
      chk("status6_invalid", invalid, 1);
      chk("status6_player", player, 0);
      press_dir(2);
      chk("left_3_to_5", nextMove, 5);
      chk("left_clears_invalid2", invalid, 0);

      // Win ends the game; everything is then ignored.
      GameStatus = 3'd1;
      do_sel(pulses);
      chk("win_pulse", pulses, 1);
      chk("win_game_over", game_over, 1);
      chk("win_player", player, 0);
      chk("win_busy", busy, 0);
      GameStatus = 3'd0;
      do_sel(pulses);
      chk("done_sel_ignored", pulses, 0);
      press_dir(0);
      press_dir(3);
      chk("done_cursor_hold", nextMove, 5);
      chk("done_hold", game_over, 1);

      // Reset during ISSUE.
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("rst2_game_over", game_over, 0);
      btn_sel = 1'b1;
      cyc(1);
      btn_sel = 1'b0;
      chk("rst_issue_move", move, 1);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("rst_mid_move", move, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_player", player, 1);
      chk("rst_mid_nextMove", nextMove, 4);
      cyc(3);
      chk("rst_mid_no_replay", move, 0);

      // sel wins over a simultaneous up press.
      btn_up = 1'b1;
      do_sel(pulses);
      btn_up = 1'b0;
      chk("sel_up_pulse", pulses, 1);
      chk("sel_up_cursor", nextMove, 4);
      chk("sel_up_player", player, 0);
      cyc(1);
      chk("sel_up_release", nextMove, 4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/move_controller.md
Name: move_controller

Overview:
- Upstream stage of the GameState block; converts debounced player buttons into move requests.
- Holds a 3x3 cursor and presents it on nextMove; issues a one-cycle move pulse on select.
- Alternates player after each accepted move; stops taking input once the game ends.
- Rejects occupied cells locally and reacts to GameState's GameStatus.

Parameters:
- RESP_WAIT, 2, cycles spent in WAIT after the move pulse before GameStatus is sampled (legal 1..15).
- START_PLAYER, 1, player to move after reset (1 = X, 0 = O).
- CURSOR_INIT, 4, cursor cell after reset (0..8, row-major, 0 = top-left).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_up  in  1  debounced level
- btn_down  in  1  debounced level
- btn_left  in  1  debounced level
- btn_right  in  1  debounced level
- btn_sel  in  1  debounced level
- X_state  in  9  occupied-by-X bitmap from GameState
- O_state  in  9  occupied-by-O bitmap from GameState
- GameStatus  in  3  0 = running, 1 = X won, 2 = O won, 3 = draw, 4 = invalid
- move  out  1  one-cycle move request to GameState
- player  out  1  current player (1 = X, 0 = O)
- nextMove  out  4  cursor cell 0..8
- busy  out  1  high in ISSUE/WAIT/CHECK
- invalid  out  1  sticky last-attempt-rejected flag
- game_over  out  1  high in DONE

Behaviour:
- Clock and reset: single clock domain; all state changes on the rising edge of clk.
- Reset values when rst=1 at an edge:
  - state = IDLE
  - move = 0, busy = 0, invalid = 0, game_over = 0
  - player = START_PLAYER
  - nextMove = CURSOR_INIT
  - button history registers = 0, WAIT counter = 0
- Reset has priority in every state, including mid-ISSUE; move is low on the cycle after the reset edge.
- Edge detect: each button is registered; a press is the sampled value = 1 while the previous sample = 0. A held button yields exactly one press.
- Presses are acted on only in IDLE. Presses in other states are discarded; history registers still update, so no press is replayed later.
- Cursor (row = nextMove/3, col = nextMove%3); all moves wrap within the grid:
  - up: row-1, wrapping 0 -> 2.
  - down: row+1, wrapping 2 -> 0.
  - left: col-1, wrapping 0 -> 2.
  - right: col+1, wrapping 2 -> 0.
  - Same-cycle press priority: sel > up > down > left > right. Only one action per cycle; the others are dropped.
  - Any accepted cursor press clears invalid.
- IDLE, sel press:
  - If (X_state|O_state)[nextMove] = 1: set invalid, stay IDLE, no move pulse.
  - Otherwise: clear invalid and go to ISSUE.
- ISSUE: move = 1 for exactly this one cycle; the WAIT counter is loaded with RESP_WAIT; go to WAIT.
- WAIT: decrement the counter each cycle; go to CHECK after RESP_WAIT cycles.
- CHECK (one cycle) samples GameStatus:
  - 0: toggle player, go to IDLE.
  - 4: set invalid, player unchanged, go to IDLE.
  - 1, 2 or 3: set game_over, go to DONE; player unchanged.
  - 5..7: treated as 4.
- DONE: all buttons ignored; outputs hold until rst.
- Latency: a sel press sampled at edge N raises move for the cycle after edge N. player toggles at edge N+2+RESP_WAIT.
- nextMove is stable from the sel press until the return to IDLE.

Test Plan:
- Reset then idle 5 cycles -> nextMove=4, player=1, move=0, invalid=0, game_over=0, busy=0.
- From 4: up, left, left, down, right presses -> nextMove 1, 0, 2, 5, 3 (wrap verified). Holding btn_right high for 10 cycles -> exactly one step.
- Empty board, sel at cell 4 -> move high exactly 1 cycle after the sampling edge. With RESP_WAIT=2 and GameStatus=0, player goes 1 -> 0 three cycles after the pulse; busy high throughout.
- X_state bit 4 set, sel at cell 4 -> no move pulse, invalid=1. A following left press clears invalid and gives nextMove=3.
- GameStatus=4 at CHECK -> invalid=1, player unchanged. GameStatus=1 at CHECK -> game_over=1; later sel/direction presses change nothing until rst.
- Assert rst during the ISSUE cycle -> move=0 on the next cycle, state IDLE, player=START_PLAYER, nextMove=CURSOR_INIT. sel+up pressed in the same IDLE cycle -> move issued, cursor unchanged.
